// File: rtl/slot_payout.sv
// Slot machine payout engine: scores the latched 3x3 grid one line per cycle, then
// dispenses coins one hopper handshake at a time. Define SLOT_DIAG_EN to also score both diagonals.
module slot_payout #(
  parameter int PAY_W       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             eval,
  input  logic [2:0]       slot_a1,
  input  logic [2:0]       slot_a2,
  input  logic [2:0]       slot_a3,
  input  logic [2:0]       slot_b1,
  input  logic [2:0]       slot_b2,
  input  logic [2:0]       slot_b3,
  input  logic [2:0]       slot_c1,
  input  logic [2:0]       slot_c2,
  input  logic [2:0]       slot_c3,
  input  logic             hopper_ack,
  output logic             coin_req,
  output logic [PAY_W-1:0] win_total,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
`ifdef SLOT_DIAG_EN
  localparam logic [3:0] NUM_LINES = 4'd8;
`else
  localparam logic [3:0] NUM_LINES = 4'd6;
`endif
  localparam logic [PAY_W:0]   SAT_MAX  = {1'b0, {PAY_W{1'b1}}};
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCORE    = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_DONE     = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  // Three equal symbols pay the symbol code; codes above 4 are blanks.
  function automatic logic [2:0] line_value(input logic [2:0] s0, input logic [2:0] s1,
                                            input logic [2:0] s2);
    logic [2:0] val;
    if ((s0 == s1) && (s1 == s2) && (s0 <= 3'd4)) begin
      val = s0;
    end else begin
      val = 3'd0;
    end
    return val;
  endfunction

  state_t           state_r, state_s;
  logic [2:0]       grid_r [9];
  logic [3:0]       idx_r, idx_s;
  logic [PAY_W-1:0] acc_r, acc_s;
  logic [PAY_W-1:0] rem_r, rem_s;
  logic [TMR_W-1:0] timer_r, timer_s;
  logic             coin_req_r, coin_req_s;
  logic [PAY_W-1:0] win_total_r, win_total_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             fault_r, fault_s;
  logic             grid_load_s;
  logic [2:0]       sym0_s, sym1_s, sym2_s;
  logic [2:0]       line_val_s;
  logic [PAY_W:0]   sum_s;
  logic [PAY_W-1:0] acc_sat_s;

  // Select the three grid cells forming the line currently being scored.
  always_comb begin
    sym0_s = 3'd0;
    sym1_s = 3'd0;
    sym2_s = 3'd0;
    case (idx_r)
      4'd0: begin sym0_s = grid_r[0]; sym1_s = grid_r[1]; sym2_s = grid_r[2]; end
      4'd1: begin sym0_s = grid_r[3]; sym1_s = grid_r[4]; sym2_s = grid_r[5]; end
      4'd2: begin sym0_s = grid_r[6]; sym1_s = grid_r[7]; sym2_s = grid_r[8]; end
      4'd3: begin sym0_s = grid_r[0]; sym1_s = grid_r[3]; sym2_s = grid_r[6]; end
      4'd4: begin sym0_s = grid_r[1]; sym1_s = grid_r[4]; sym2_s = grid_r[7]; end
      4'd5: begin sym0_s = grid_r[2]; sym1_s = grid_r[5]; sym2_s = grid_r[8]; end
`ifdef SLOT_DIAG_EN
      4'd6: begin sym0_s = grid_r[0]; sym1_s = grid_r[4]; sym2_s = grid_r[8]; end
      4'd7: begin sym0_s = grid_r[2]; sym1_s = grid_r[4]; sym2_s = grid_r[6]; end
`endif
      default: begin sym0_s = 3'd0; sym1_s = 3'd0; sym2_s = 3'd0; end
    endcase
  end

  // Saturating accumulate of the current line's payout.
  always_comb begin
    line_val_s = line_value(sym0_s, sym1_s, sym2_s);
    sum_s      = {1'b0, acc_r} + {{(PAY_W-2){1'b0}}, line_val_s};
    if (sum_s > SAT_MAX) begin
      acc_sat_s = {PAY_W{1'b1}};
    end else begin
      acc_sat_s = sum_s[PAY_W-1:0];
    end
  end

  // Next-state and next-output logic; busy/done trail the state by one cycle.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    acc_s       = acc_r;
    rem_s       = rem_r;
    timer_s     = timer_r;
    coin_req_s  = coin_req_r;
    win_total_s = win_total_r;
    fault_s     = fault_r;
    grid_load_s = 1'b0;
    busy_s      = (state_r != ST_IDLE);
    done_s      = (state_r == ST_DONE);
    case (state_r)
      ST_IDLE: begin
        if (eval) begin
          grid_load_s = 1'b1;
          acc_s       = {PAY_W{1'b0}};
          idx_s       = 4'd0;
          state_s     = ST_SCORE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCORE: begin
        if (idx_r == NUM_LINES) begin
          win_total_s = acc_r;
          if (acc_r == {PAY_W{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            rem_s      = acc_r;
            timer_s    = {TMR_W{1'b0}};
            coin_req_s = 1'b1;
            state_s    = ST_DISPENSE;
          end
        end else begin
          acc_s = acc_sat_s;
          idx_s = idx_r + 4'd1;
        end
      end
      ST_DISPENSE: begin
        if (coin_req_r) begin
          if (hopper_ack) begin
            rem_s      = rem_r - PAY_W'(1);
            coin_req_s = 1'b0;
            timer_s    = {TMR_W{1'b0}};
            if (rem_r == PAY_W'(1)) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_DISPENSE;
            end
          end else if (timer_r == TMR_LAST) begin
            timer_s    = timer_r + TMR_W'(1);
            coin_req_s = 1'b0;
            fault_s    = 1'b1;
            state_s    = ST_FAULT;
          end else begin
            timer_s = timer_r + TMR_W'(1);
          end
        end else begin
          // One-cycle gap after each coin; any ack seen here is a stray.
          coin_req_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      ST_FAULT: begin
        coin_req_s = 1'b0;
        fault_s    = 1'b1;
        state_s    = ST_FAULT;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r     <= ST_IDLE;
      idx_r       <= 4'd0;
      acc_r       <= {PAY_W{1'b0}};
      rem_r       <= {PAY_W{1'b0}};
      timer_r     <= {TMR_W{1'b0}};
      coin_req_r  <= 1'b0;
      win_total_r <= {PAY_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      acc_r       <= acc_s;
      rem_r       <= rem_s;
      timer_r     <= timer_s;
      coin_req_r  <= coin_req_s;
      win_total_r <= win_total_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      fault_r     <= fault_s;
    end
  end

  // Grid snapshot, taken only when an eval is accepted.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 9; i++) begin
        grid_r[i] <= 3'd0;
      end
    end else if (grid_load_s) begin
      grid_r[0] <= slot_a1;
      grid_r[1] <= slot_a2;
      grid_r[2] <= slot_a3;
      grid_r[3] <= slot_b1;
      grid_r[4] <= slot_b2;
      grid_r[5] <= slot_b3;
      grid_r[6] <= slot_c1;
      grid_r[7] <= slot_c2;
      grid_r[8] <= slot_c3;
    end else begin
      for (int i = 0; i < 9; i++) begin
        grid_r[i] <= grid_r[i];
      end
    end
  end

  assign coin_req  = coin_req_r;
  assign win_total = win_total_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign fault     = fault_r;

endmodule
